// File: rtl/fsm_table_sequencer_pkg.sv
// Shared encodings for the table-driven sequencer: operating modes,
// error codes and config-port table selection.
package fsm_table_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_ERROR = 2'd2
    } mode_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_SYM   = 2'd1;
    localparam logic [1:0] ERR_BAD_STATE = 2'd2;
    localparam logic [1:0] ERR_CFG_RUN   = 2'd3;

    localparam logic CFG_SEL_TRANS = 1'b0;
    localparam logic CFG_SEL_OUT   = 1'b1;

endpackage

// File: rtl/fsm_table_sequencer_if.sv
// Config-write port plus the input-symbol handshake of the sequencer.
interface fsm_table_sequencer_if #(
    parameter int SW = 3,
    parameter int OW = 4
);
    logic          cfg_we;
    logic          cfg_sel;
    logic [SW-1:0] cfg_state;
    logic [SW-1:0] cfg_in;
    logic [OW-1:0] cfg_data;
    logic          in_valid;
    logic [SW-1:0] in_sym;
    logic          in_ready;

    modport master (
        output cfg_we, cfg_sel, cfg_state, cfg_in, cfg_data, in_valid, in_sym,
        input  in_ready
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_state, cfg_in, cfg_data, in_valid, in_sym,
        output in_ready
    );
endinterface

// File: rtl/fsm_table_sequencer_ram.sv
// Transition and output tables: synchronous write with index range check,
// asynchronous read of the next state and of the current state's output.
module fsm_table_ram
    import fsm_table_sequencer_pkg::*;
#(
    parameter int NUM_STATES = 5,
    parameter int NUM_INPUTS = 5,
    parameter int SW         = 3,
    parameter int OW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          sel,
    input  logic [SW-1:0] wr_state,
    input  logic [SW-1:0] wr_in,
    input  logic [OW-1:0] wr_data,
    output logic          wr_bad_index,
    input  logic [SW-1:0] rd_state,
    input  logic [SW-1:0] rd_sym,
    output logic [SW-1:0] rd_next,
    output logic          rd_sym_ok,
    output logic [OW-1:0] rd_out
);

    logic [SW-1:0] trans_tab [NUM_STATES][NUM_INPUTS];
    logic [OW-1:0] out_tab   [NUM_STATES];

    logic wr_state_ok;
    logic wr_in_ok;

    assign wr_state_ok  = int'(wr_state) < NUM_STATES;
    assign wr_in_ok     = int'(wr_in) < NUM_INPUTS;
    // The column index only matters for transition entries.
    assign wr_bad_index = !wr_state_ok || ((sel == CFG_SEL_TRANS) && !wr_in_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                out_tab[s] <= '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    trans_tab[s][i] <= '0;
                end
            end
        end else if (we && !wr_bad_index) begin
            if (sel == CFG_SEL_TRANS) begin
                trans_tab[wr_state][wr_in] <= wr_data[SW-1:0];
            end else begin
                out_tab[wr_state] <= wr_data;
            end
        end
    end

    // Out-of-range read indices yield zero rather than touching the arrays.
    always_comb begin
        rd_next   = '0;
        rd_out    = '0;
        rd_sym_ok = int'(rd_sym) < NUM_INPUTS;
        if (int'(rd_state) < NUM_STATES) begin
            rd_out = out_tab[rd_state];
            if (rd_sym_ok) begin
                rd_next = trans_tab[rd_state][rd_sym];
            end
        end
    end

endmodule

// File: rtl/fsm_table_sequencer.sv
// Mode FSM and step logic of the table-driven Moore sequencer; the tables
// themselves live in fsm_table_ram.
module fsm_table_sequencer
    import fsm_table_sequencer_pkg::*;
#(
    parameter int NUM_STATES = 5,
    parameter int NUM_INPUTS = 5,
    parameter int SW         = 3,
    parameter int OW         = 4,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  restart,
    input  logic                  clear_err,
    fsm_table_sequencer_if.slave  bus,
    output logic [SW-1:0]         cur_state,
    output logic [OW-1:0]         out,
    output logic [1:0]            mode,
    output logic [1:0]            err_code,
    output logic                  cfg_err,
    output logic [CW-1:0]         step_cnt
);

    mode_t         mode_q, mode_d;
    logic [1:0]    err_q, err_d;
    logic [SW-1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cfg_err_q, cfg_err_d;

    logic          cfg_write_en;
    logic          wr_bad_index;
    logic [SW-1:0] rd_next;
    logic          rd_sym_ok;
    logic [OW-1:0] rd_out;
    logic          next_ok;
    logic          step_req;

    assign cfg_write_en = bus.cfg_we && (mode_q == MODE_IDLE);

    fsm_table_ram #(
        .NUM_STATES (NUM_STATES),
        .NUM_INPUTS (NUM_INPUTS),
        .SW         (SW),
        .OW         (OW)
    ) u_ram (
        .clk          (clk),
        .reset        (reset),
        .we           (cfg_write_en),
        .sel          (bus.cfg_sel),
        .wr_state     (bus.cfg_state),
        .wr_in        (bus.cfg_in),
        .wr_data      (bus.cfg_data),
        .wr_bad_index (wr_bad_index),
        .rd_state     (state_q),
        .rd_sym       (bus.in_sym),
        .rd_next      (rd_next),
        .rd_sym_ok    (rd_sym_ok),
        .rd_out       (rd_out)
    );

    assign bus.in_ready = (mode_q == MODE_RUN);
    assign next_ok      = int'(rd_next) < NUM_STATES;
    // halt and restart both suppress any step offered in the same cycle.
    assign step_req     = bus.in_valid && bus.in_ready && !halt && !restart;

    always_comb begin
        mode_d    = mode_q;
        err_d     = err_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_err_d = bus.cfg_we && ((mode_q != MODE_IDLE) || wr_bad_index);

        unique case (mode_q)
            MODE_IDLE: begin
                if (start && !halt) begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_RUN: begin
                if (bus.cfg_we) begin
                    err_d = ERR_CFG_RUN;
                end
                if (halt) begin
                    mode_d = MODE_IDLE;
                end else if (step_req) begin
                    if (!rd_sym_ok) begin
                        mode_d = MODE_ERROR;
                        err_d  = ERR_BAD_SYM;
                    end else if (!next_ok) begin
                        mode_d = MODE_ERROR;
                        err_d  = ERR_BAD_STATE;
                    end else begin
                        state_d = rd_next;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            MODE_ERROR: begin
                if (clear_err) begin
                    mode_d = MODE_IDLE;
                    err_d  = ERR_NONE;
                end
            end
            default: begin
                mode_d = MODE_IDLE;
            end
        endcase

        // restart acts in every mode and leaves mode/err_code alone.
        if (restart) begin
            state_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_IDLE;
            err_q     <= ERR_NONE;
            state_q   <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            err_q     <= err_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cur_state = state_q;
    assign out       = rd_out;
    assign mode      = mode_q;
    assign err_code  = err_q;
    assign cfg_err   = cfg_err_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Directed bench for fsm_table_sequencer: a reference model feeds a scoreboard
// of expected step results; a second CW=2 instance shadows the first.
module tb_fsm_table_sequencer;

    logic clk = 1'b0;
    logic reset, start, halt, restart, clear_err;

    logic [2:0]  cur_state, cur_state2;
    logic [3:0]  out, out2;
    logic [1:0]  mode, mode2, err_code, err_code2;
    logic        cfg_err, cfg_err2;
    logic [15:0] step_cnt;
    logic [1:0]  step_cnt2;

    int tests_run = 0;
    int fail_cnt  = 0;

    int m_trans [5][5];
    int m_out   [5];
    int m_state, m_cnt, m_cnt2, m_mode, m_err;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  o;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [1:0]  md;
        logic [1:0]  ec;
    } exp_t;

    exp_t sb[$];

    fsm_table_sequencer_if #(.SW(3), .OW(4)) bus ();
    fsm_table_sequencer_if #(.SW(3), .OW(4)) bus2 ();

    assign bus2.cfg_we    = bus.cfg_we;
    assign bus2.cfg_sel   = bus.cfg_sel;
    assign bus2.cfg_state = bus.cfg_state;
    assign bus2.cfg_in    = bus.cfg_in;
    assign bus2.cfg_data  = bus.cfg_data;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_sym    = bus.in_sym;

    fsm_table_sequencer #(.NUM_STATES(5), .NUM_INPUTS(5), .SW(3), .OW(4), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .restart(restart),
        .clear_err(clear_err), .bus(bus), .cur_state(cur_state), .out(out),
        .mode(mode), .err_code(err_code), .cfg_err(cfg_err), .step_cnt(step_cnt)
    );

    fsm_table_sequencer #(.NUM_STATES(5), .NUM_INPUTS(5), .SW(3), .OW(4), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .restart(restart),
        .clear_err(clear_err), .bus(bus2), .cur_state(cur_state2), .out(out2),
        .mode(mode2), .err_code(err_code2), .cfg_err(cfg_err2), .step_cnt(step_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfgWrite(input logic sel, input int st, input int col, input int data,
                            input logic exp_err);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_state = 3'(st);
        bus.cfg_in    = 3'(col);
        bus.cfg_data  = 4'(data);
        tick();
        bus.cfg_we = 1'b0;
        checkOutput("cfg_err", 32'(cfg_err), 32'(exp_err));
        if (!exp_err) begin
            if (sel) m_out[st] = data;
            else     m_trans[st][col] = data;
        end
    endtask

    // One offered symbol in RUN; the model's prediction goes through the scoreboard.
    task automatic applyStimulus(input logic [2:0] sym);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_sym   = sym;
        if (int'(sym) >= 5) begin
            m_mode = 2;
            m_err  = 1;
        end else if (m_trans[m_state][sym] >= 5) begin
            m_mode = 2;
            m_err  = 2;
        end else begin
            m_state = m_trans[m_state][sym];
            if (m_cnt != 65535) m_cnt++;
            if (m_cnt2 != 3) m_cnt2++;
        end
        e.st   = 3'(m_state);
        e.o    = 4'(m_out[m_state]);
        e.cnt  = 16'(m_cnt);
        e.cnt2 = 2'(m_cnt2);
        e.md   = 2'(m_mode);
        e.ec   = 2'(m_err);
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        checkOutput("step cur_state", 32'(cur_state), 32'(e.st));
        checkOutput("step out", 32'(out), 32'(e.o));
        checkOutput("step step_cnt", 32'(step_cnt), 32'(e.cnt));
        checkOutput("step step_cnt CW2", 32'(step_cnt2), 32'(e.cnt2));
        checkOutput("step mode", 32'(mode), 32'(e.md));
        checkOutput("step err_code", 32'(err_code), 32'(e.ec));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; restart = 1'b0; clear_err = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_state = '0; bus.cfg_in = '0;
        bus.cfg_data = '0; bus.in_valid = 1'b0; bus.in_sym = '0;
        for (int s = 0; s < 5; s++) begin
            m_out[s] = 0;
            for (int i = 0; i < 5; i++) m_trans[s][i] = 0;
        end
        m_state = 0; m_cnt = 0; m_cnt2 = 0; m_mode = 0; m_err = 0;

        tick(); tick();
        reset = 1'b0;
        tick();
        checkOutput("reset mode", 32'(mode), 0);
        checkOutput("reset cur_state", 32'(cur_state), 0);
        checkOutput("reset out", 32'(out), 0);
        checkOutput("reset err_code", 32'(err_code), 0);
        checkOutput("reset cfg_err", 32'(cfg_err), 0);
        checkOutput("reset step_cnt", 32'(step_cnt), 0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 0);

        // 1: all-zero table, three steps
        start = 1'b1; tick(); start = 1'b0; m_mode = 1;
        checkOutput("start mode", 32'(mode), 1);
        checkOutput("start in_ready", 32'(bus.in_ready), 1);
        for (int k = 0; k < 3; k++) applyStimulus(3'd0);
        checkOutput("t1 step_cnt", 32'(step_cnt), 3);

        // 2: ring table
        halt = 1'b1; tick(); halt = 1'b0; m_mode = 0;
        checkOutput("halt mode", 32'(mode), 0);
        for (int s = 0; s < 5; s++) begin
            cfgWrite(1'b0, s, 1, (s + 1) % 5, 1'b0);
            cfgWrite(1'b1, s, 0, s + 8, 1'b0);
        end
        checkOutput("ring out at state0", 32'(out), 8);
        start = 1'b1; tick(); start = 1'b0; m_mode = 1;
        for (int k = 0; k < 6; k++) applyStimulus(3'd1);
        checkOutput("ring final state", 32'(cur_state), 1);
        checkOutput("ring final out", 32'(out), 9);
        checkOutput("CW2 saturated", 32'(step_cnt2), 3);

        // 3: bad symbol, then ERROR ignores steps, clear_err
        applyStimulus(3'd6);
        checkOutput("error in_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1; bus.in_sym = 3'd1; tick(); bus.in_valid = 1'b0;
        checkOutput("error frozen state", 32'(cur_state), 32'(m_state));
        checkOutput("error frozen mode", 32'(mode), 2);
        clear_err = 1'b1; tick(); clear_err = 1'b0; m_mode = 0; m_err = 0;
        checkOutput("clear_err mode", 32'(mode), 0);
        checkOutput("clear_err err_code", 32'(err_code), 0);

        // 4: restart in IDLE, then illegal next state
        restart = 1'b1; tick(); restart = 1'b0; m_state = 0; m_cnt = 0; m_cnt2 = 0;
        checkOutput("restart idle state", 32'(cur_state), 0);
        checkOutput("restart idle cnt", 32'(step_cnt), 0);
        checkOutput("restart idle mode", 32'(mode), 0);
        cfgWrite(1'b0, 0, 2, 7, 1'b0);
        start = 1'b1; tick(); start = 1'b0; m_mode = 1;
        applyStimulus(3'd2);
        clear_err = 1'b1; tick(); clear_err = 1'b0; m_mode = 0; m_err = 0;

        // 5: config write rejected in RUN and out of range in IDLE
        start = 1'b1; tick(); start = 1'b0; m_mode = 1;
        bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_state = 3'd0; bus.cfg_data = 4'd15;
        tick(); bus.cfg_we = 1'b0; m_err = 3;
        checkOutput("run cfg_err", 32'(cfg_err), 1);
        checkOutput("run cfg err_code", 32'(err_code), 3);
        checkOutput("run cfg mode", 32'(mode), 1);
        checkOutput("run cfg out unchanged", 32'(out), 8);
        tick();
        checkOutput("cfg_err one cycle", 32'(cfg_err), 0);
        applyStimulus(3'd1);
        halt = 1'b1; tick(); halt = 1'b0; m_mode = 0;
        cfgWrite(1'b1, 5, 0, 3, 1'b1);
        cfgWrite(1'b0, 0, 5, 1, 1'b1);
        checkOutput("range out unchanged", 32'(out), 9);

        // 6: start+halt, write+start, restart+step, saturation
        start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
        checkOutput("start+halt mode", 32'(mode), 0);
        bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_state = 3'd2; bus.cfg_data = 4'd5;
        start = 1'b1; tick(); bus.cfg_we = 1'b0; start = 1'b0;
        m_out[2] = 5; m_mode = 1;
        checkOutput("write+start mode", 32'(mode), 1);
        applyStimulus(3'd1);
        bus.in_valid = 1'b1; bus.in_sym = 3'd1; restart = 1'b1;
        tick(); bus.in_valid = 1'b0; restart = 1'b0;
        m_state = 0; m_cnt = 0; m_cnt2 = 0;
        checkOutput("restart+step state", 32'(cur_state), 0);
        checkOutput("restart+step cnt", 32'(step_cnt), 0);
        checkOutput("restart+step mode", 32'(mode), 1);
        checkOutput("restart+step out", 32'(out), 8);
        for (int k = 0; k < 5; k++) applyStimulus(3'd1);
        checkOutput("final cnt", 32'(step_cnt), 5);
        checkOutput("final CW2 cnt", 32'(step_cnt2), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
